// File: rtl/afifo_pkg.sv
// ============================================================================
// afifo_pkg : shared FSM state type and default sizing for afifo_wr_arb
// Revision  : 1.0
// ============================================================================
`default_nettype none

package afifo_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  localparam int NREQ_DEF  = 4;
  localparam int BURST_DEF = 4;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// rr_pick : combinational round-robin search, first set req at/above rr_ptr
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IDXW = $clog2(NREQ);

  // Walk offsets from farthest to nearest so the nearest set bit wins last.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % NREQ]) begin
        idx = IDXW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/afifo_wr_arb.sv
// ============================================================================
// afifo_wr_arb : round-robin burst arbiter feeding one FIFO write port.
// Optional macro AFIFO_ARB_STALL_CNT_EN adds a saturating 16-bit stall_cnt.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module afifo_wr_arb
  import afifo_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int DSIZE = 8,
  parameter int BURST = BURST_DEF
) (
  input  logic                    wclk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  output logic [NREQ-1:0]         ack,
  input  logic                    wfull,
  output logic                    winc,
  output logic [DSIZE-1:0]        wdata,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    busy
`ifdef AFIFO_ARB_STALL_CNT_EN
  ,
  output logic [15:0]             stall_cnt
`endif
);

  localparam int IDXW = $clog2(NREQ);
  localparam int CW   = $clog2(BURST + 1);

  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0] gnt_q, gnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            pick_valid;
  logic [IDXW-1:0] pick_idx;
  logic            req_g;
  logic            end_burst;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  always_comb begin
    req_g  = req[gnt_q];
    busy   = (state_q == ST_BURST);
    winc   = busy & req_g & ~wfull;
    ack    = '0;
    ack[gnt_q] = winc;
    wdata  = busy ? req_data[gnt_q*DSIZE +: DSIZE] : '0;
    gnt_id = gnt_q;
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    end_burst = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Decision cycle only; the first word goes out next cycle.
        if (pick_valid) begin
          state_d = ST_BURST;
          gnt_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_BURST: begin
        if (!req_g) begin
          end_burst = 1'b1;
        end else if (winc) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(BURST - 1)) begin
            end_burst = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (end_burst) begin
      state_d  = ST_IDLE;
      rr_ptr_d = (gnt_q == IDXW'(NREQ - 1)) ? '0 : gnt_q + IDXW'(1);
    end
  end

  always_ff @(posedge wclk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef AFIFO_ARB_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (busy && req_g && wfull && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge wclk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_afifo_wr_arb.sv
// ============================================================================
// tb_afifo_wr_arb : randomized bench for afifo_wr_arb with a reference model
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_afifo_wr_arb;

  localparam int NREQ  = 4;
  localparam int DSIZE = 8;
  localparam int BURST = 4;
  localparam int IDXW  = $clog2(NREQ);

  logic                  wclk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       ack;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [IDXW-1:0]       gnt_id;
  logic                  busy;
`ifdef AFIFO_ARB_STALL_CNT_EN
  logic [15:0]           stall_cnt;
`endif

  afifo_wr_arb #(
    .NREQ  (NREQ),
    .DSIZE (DSIZE),
    .BURST (BURST)
  ) dut (
    .wclk     (wclk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .wfull    (wfull),
    .winc     (winc),
    .wdata    (wdata),
    .gnt_id   (gnt_id),
    .busy     (busy)
`ifdef AFIFO_ARB_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who holds the grant, words sent, next search start.
  bit m_busy;
  int m_holder;
  int m_words;
  int m_ptr;
  int m_stall;

  // Grant-order tracking for the all-requesters phase.
  bit track;
  bit prev_busy;
  int grants[$];
  int wcount;
  int idle_run;

  task automatic model_reset();
    m_busy = 0; m_holder = 0; m_words = 0; m_ptr = 0; m_stall = 0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (!m_busy) begin
      for (int off = 0; off < NREQ; off++) begin
        if (!m_busy && req[(m_ptr + off) % NREQ]) begin
          m_busy = 1; m_holder = (m_ptr + off) % NREQ; m_words = 0;
        end
      end
    end else begin
      bit finish;
      finish = 0;
      if (!req[m_holder]) finish = 1;
      else if (wfull) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      else begin
        m_words++;
        if (m_words == BURST) finish = 1;
      end
      if (finish) begin
        m_busy = 0;
        m_ptr  = (m_holder + 1) % NREQ;
      end
    end
  endtask

  task automatic run_cycle();
    logic            e_winc;
    logic [NREQ-1:0] e_ack;
    logic [DSIZE-1:0] e_wdata;
    #1;
    e_winc  = m_busy && req[m_holder] && !wfull;
    e_ack   = e_winc ? (NREQ'(1) << m_holder) : '0;
    e_wdata = m_busy ? req_data[m_holder*DSIZE +: DSIZE] : '0;
    chk("busy",  32'(busy),  32'(m_busy));
    chk("winc",  32'(winc),  32'(e_winc));
    chk("ack",   32'(ack),   32'(e_ack));
    chk("wdata", 32'(wdata), 32'(e_wdata));
    if (m_busy) chk("gnt_id", 32'(gnt_id), 32'(m_holder));
`ifdef AFIFO_ARB_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    if (track) begin
      if (busy && !prev_busy) begin
        if (grants.size() > 0) chk("idle_gap", 32'(idle_run), 32'd1);
        grants.push_back(int'(gnt_id));
      end
      if (busy && winc) wcount++;
      if (!busy && prev_busy) begin
        chk("burst_len", 32'(wcount), 32'(BURST));
        wcount = 0;
      end
      idle_run  = busy ? 0 : idle_run + 1;
      prev_busy = busy;
    end
    @(posedge wclk);
    model_edge();
    @(negedge wclk);
  endtask

  initial begin
    int exp_order[5];
    rst_n = 1'b0; req = '0; wfull = 1'b0; req_data = '0;
    track = 0; prev_busy = 0; wcount = 0; idle_run = 0;
    @(posedge wclk);
    @(negedge wclk);
    model_reset();
    run_cycle();

    // All requesters held, no back-pressure: strict 0,1,2,3,0 rotation.
    rst_n = 1'b1; req = '1; track = 1;
    for (int c = 0; c < 26; c++) begin
      req_data = $urandom;
      run_cycle();
    end
    track = 0;
    exp_order = '{0, 1, 2, 3, 0};
    chk("grant_count", 32'(grants.size() >= 5), 32'd1);
    for (int g = 0; g < 5; g++) begin
      if (g < grants.size()) chk("grant_order", 32'(grants[g]), 32'(exp_order[g]));
    end

    // Random traffic with sticky requests, back-pressure and occasional reset.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          if ($urandom_range(0, 9) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
        end
      end
      wfull    = ($urandom_range(0, 3) == 0);
      req_data = $urandom;
      rst_n    = ($urandom_range(0, 149) != 0);
      run_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
